ssp_uart_cmd_seq: RTL and testbench
===================================

// Module: ssp_uart_cmd_seq
// PURPOSE
//  Two-requester command sequencer/arbiter that owns the parallel SSP register port of SSP_UART.
//  Round-robin arbitrates register read/write requests from requesters A and B.
//  Sequences each granted request into one framed SSP cycle (SSEL, SCK, RA, WnR, En, EOC, DI), captures SSP_DO.
//  Returns read data and a one-cycle Ack to the granted requester; sits between host-side logic and SSP_UART.
// PARAMETERS
//  pSCK_Div  2       Clk cycles per SCK half-period (D); legal range 1..255
//  pPollRA   3'b000  SSP register address read by the IRQ auto-poll (used only with SSP_SEQ_IRQ_POLL_EN)
// PORTS
//  Clk       in   1   system clock; all logic on rising edge
//  Rst       in   1   synchronous, active-high reset
//  ReqA      in   1   requester A request (level, hold until AckA)
//  WnRA      in   1   A: 1=write, 0=read
//  RAA       in   3   A register address
//  DIA       in   12  A write data
//  AckA      out  1   A one-cycle completion pulse
//  DOA       out  12  A read data, valid with AckA
//  ReqB/WnRB/RAB/DIB/AckB/DOB: same as A, for requester B
//  SSP_SSEL  out  1   frame select to SSP_UART
//  SSP_SCK   out  1   SSP serial clock
//  SSP_RA    out  3   register address for the frame
//  SSP_WnR   out  1   frame command
//  SSP_En    out  1   data-phase enable (bits 11:0)
//  SSP_EOC   out  1   end-of-cycle strobe
//  SSP_DI    out  12  write data to SSP_UART
//  SSP_DO    in   12  read data from SSP_UART
//  Busy      out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, RR pointer=A; every output 0 (SSEL, SCK, En, EOC, Acks, Busy, RA, WnR, DI, DOA, DOB).
//  FSM IDLE->SETUP->SHIFT->ENDC->ACK->IDLE.
//  IDLE: sample ReqA/ReqB (cycle 0); if any, grant per RR pointer, latch RA/WnR/DI/owner, go SETUP.
//   RR: the pointer names the preferred requester; after a grant it moves to the other one.
//   Lone request always wins.
//  SETUP: D cycles; SSEL=1, SCK=0; RA/WnR/DI driven, held constant until ACK.
//  SHIFT: 32 half-periods of D cycles each (low then high, starting low); bit counter 15..0.
//   Counter decrements at the end of each high half.
//   En=1 while bit counter<=11; En=0 for bits 15..12.
//  ENDC: 1 cycle; SCK=0, EOC=1, SSP_DO captured into owner's DO register if WnR=0.
//   Owner's DO holds its previous value on writes.
//  ACK: 1 cycle; SSEL=0, owner's Ack=1; next cycle IDLE (min 1 IDLE cycle between frames).
//  Latency: Ack asserted at cycle 2+33*D after the IDLE sample cycle (D=1 -> 35, D=2 -> 68).
//  Req dropped before grant: ignored.
//  Req dropped after grant: the frame still completes and Ack is still issued.
//  Re-arbitration happens only in IDLE.
//  Req held high after Ack: treated as a new request at the next IDLE.
//  Rst mid-frame: outputs return to reset values at the next edge; frame abandoned; no Ack; pointer=A.
//  SCK/En/EOC/SSEL are registered outputs (glitch-free).
// CONFIGURATION
//  Macro SSP_SEQ_IRQ_POLL_EN.
//  Defined:
//   Adds ports IRQ (in, 1), PollVld (out, 1), PollDO (out, 12).
//   A rising edge of registered IRQ sets PollPend.
//   In IDLE, PollPend has priority over A and B; it issues a read of pPollRA and clears PollPend on grant.
//   The RR pointer is unchanged by a poll.
//   ENDC captures SSP_DO into PollDO; ACK pulses PollVld instead of AckA/AckB.
//   IRQ edges during a poll frame set PollPend again.
//  Undefined: the IRQ, PollVld and PollDO ports and all poll logic are absent.
// TESTING
//  T1 D=1, write A RA=3 DI=0x5A5 -> SSEL=1 cycles 1..34; RA=3, WnR=1, DI=0x5A5; En high 12 SCK periods; one EOC at cycle 34; AckA at 35.
//  T2 read B RA=5, model drives SSP_DO=0xABC -> DOB=0xABC with AckB; DOA unchanged.
//  T3 ReqA and ReqB held high together from reset for 4 frames -> grant order A,B,A,B; 1 IDLE cycle between frames.
//  T4 Rst pulsed at cycle 10 of an A frame -> SSEL/SCK/En=0 next cycle; no AckA; a re-issued ReqA then completes a full frame.
//  T5 D=3 -> SCK high 3 / low 3 cycles; Ack at cycle 101; exactly 16 SCK rising edges per frame.
//  T6 (SSP_SEQ_IRQ_POLL_EN, pPollRA=0) IRQ rises during an A frame while ReqB pending -> after AckA, poll read RA=0 runs; PollVld with PollDO=SSP_DO; then B frame.

Source files
------------

// File: rtl/ssp_uart_cmd_seq.sv
// ssp_uart_cmd_seq
//   Two-requester command sequencer that owns the parallel SSP register port
//   of SSP_UART. Requests from A and B are round-robin arbitrated in IDLE. Each
//   grant becomes one framed SSP cycle: SETUP (D clocks), SHIFT (16 SCK periods,
//   each D clocks low then D clocks high), ENDC (EOC strobe, SSP_DO capture) and
//   ACK (one-cycle Ack to the owner).
//
// Parameters
//   pSCK_Div  clocks per SCK half-period (1..255)
//   pPollRA   register address read by the IRQ auto-poll
//
// Ports
//   Clk, Rst                  clock, synchronous active-high reset
//   ReqX/WnRX/RAX/DIX         requester X (A or B) request, command, address, data
//   AckX/DOX                  requester X completion pulse and read data
//   SSP_SSEL/SCK/RA/WnR/En/EOC/DI, SSP_DO   SSP_UART register port
//   Busy                      high whenever the sequencer is not idle
//
// Optional feature (macro SSP_SEQ_IRQ_POLL_EN)
//   Adds IRQ (in), PollVld (out) and PollDO (out). A rising edge of the
//   registered IRQ queues a read of pPollRA that takes priority over A and B in
//   IDLE; its result is returned on PollDO with a PollVld pulse.
module ssp_uart_cmd_seq #(
  parameter int unsigned pSCK_Div = 2,
  parameter logic [2:0]  pPollRA  = 3'b000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqA,
  input  logic        WnRA,
  input  logic [2:0]  RAA,
  input  logic [11:0] DIA,
  output logic        AckA,
  output logic [11:0] DOA,
  input  logic        ReqB,
  input  logic        WnRB,
  input  logic [2:0]  RAB,
  input  logic [11:0] DIB,
  output logic        AckB,
  output logic [11:0] DOB,
  output logic        SSP_SSEL,
  output logic        SSP_SCK,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic        SSP_En,
  output logic        SSP_EOC,
  output logic [11:0] SSP_DI,
  input  logic [11:0] SSP_DO,
`ifdef SSP_SEQ_IRQ_POLL_EN
  input  logic        IRQ,
  output logic        PollVld,
  output logic [11:0] PollDO,
`endif
  output logic        Busy
);

  localparam logic [7:0] DIV_LAST = 8'(pSCK_Div - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_ENDC, S_ACK} state_t;
  typedef enum logic [1:0] {OWN_A, OWN_B, OWN_POLL} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        rr_b_q, rr_b_d;     // 1: B is the preferred requester
  logic [7:0]  div_q, div_d;
  logic        half_q, half_d;     // 0: SCK low half, 1: SCK high half
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  ra_q, ra_d;
  logic        wnr_q, wnr_d;
  logic [11:0] di_q, di_d;
  logic [11:0] doa_q, doa_d;
  logic [11:0] dob_q, dob_d;
  logic        ssel_q, ssel_d;
  logic        sck_q, sck_d;
  logic        en_q, en_d;
  logic        eoc_q, eoc_d;
  logic        acka_q, acka_d;
  logic        ackb_q, ackb_d;
  logic        grant_poll;
  logic        pick_b;

`ifdef SSP_SEQ_IRQ_POLL_EN
  logic        irq_s_q, irq_s2_q;
  logic        poll_pend_q, poll_pend_d;
  logic        poll_vld_q, poll_vld_d;
  logic [11:0] poll_do_q, poll_do_d;
  logic        irq_rise;

  assign irq_rise   = irq_s_q & ~irq_s2_q;
  assign grant_poll = poll_pend_q;
`else
  assign grant_poll = 1'b0;
`endif

  // A lone request always wins; with both pending the pointer decides.
  assign pick_b = ReqB & (~ReqA | rr_b_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_b_d  = rr_b_q;
    div_d   = div_q;
    half_d  = half_q;
    bit_d   = bit_q;
    ra_d    = ra_q;
    wnr_d   = wnr_q;
    di_d    = di_q;
    doa_d   = doa_q;
    dob_d   = dob_q;
`ifdef SSP_SEQ_IRQ_POLL_EN
    poll_do_d   = poll_do_q;
    poll_pend_d = poll_pend_q | irq_rise;
`endif

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (grant_poll) begin
          // Poll leaves the round-robin pointer untouched.
          owner_d = OWN_POLL;
          ra_d    = pPollRA;
          wnr_d   = 1'b0;
          di_d    = '0;
          state_d = S_SETUP;
`ifdef SSP_SEQ_IRQ_POLL_EN
          poll_pend_d = irq_rise;
`endif
        end else if (ReqA | ReqB) begin
          owner_d = pick_b ? OWN_B : OWN_A;
          ra_d    = pick_b ? RAB : RAA;
          wnr_d   = pick_b ? WnRB : WnRA;
          di_d    = pick_b ? DIB : DIA;
          rr_b_d  = ~pick_b;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = 4'd15;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_q == 4'd0) state_d = S_ENDC;
            else               bit_d   = bit_q - 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_ENDC: begin
        if (!wnr_q) begin
          if (owner_q == OWN_A)      doa_d = SSP_DO;
          else if (owner_q == OWN_B) dob_d = SSP_DO;
`ifdef SSP_SEQ_IRQ_POLL_EN
          else                       poll_do_d = SSP_DO;
`endif
        end
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Port strobes are decoded from the next state so they leave flops.
    ssel_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_ENDC);
    sck_d  = (state_d == S_SHIFT) && half_d;
    en_d   = (state_d == S_SHIFT) && (bit_d <= 4'd11);
    eoc_d  = (state_d == S_ENDC);
    acka_d = (state_d == S_ACK) && (owner_d == OWN_A);
    ackb_d = (state_d == S_ACK) && (owner_d == OWN_B);
`ifdef SSP_SEQ_IRQ_POLL_EN
    poll_vld_d = (state_d == S_ACK) && (owner_d == OWN_POLL);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_A;
      rr_b_q  <= 1'b0;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      ra_q    <= '0;
      wnr_q   <= 1'b0;
      di_q    <= '0;
      doa_q   <= '0;
      dob_q   <= '0;
      ssel_q  <= 1'b0;
      sck_q   <= 1'b0;
      en_q    <= 1'b0;
      eoc_q   <= 1'b0;
      acka_q  <= 1'b0;
      ackb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_b_q  <= rr_b_d;
      div_q   <= div_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      ra_q    <= ra_d;
      wnr_q   <= wnr_d;
      di_q    <= di_d;
      doa_q   <= doa_d;
      dob_q   <= dob_d;
      ssel_q  <= ssel_d;
      sck_q   <= sck_d;
      en_q    <= en_d;
      eoc_q   <= eoc_d;
      acka_q  <= acka_d;
      ackb_q  <= ackb_d;
    end
  end

`ifdef SSP_SEQ_IRQ_POLL_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      irq_s_q     <= 1'b0;
      irq_s2_q    <= 1'b0;
      poll_pend_q <= 1'b0;
      poll_vld_q  <= 1'b0;
      poll_do_q   <= '0;
    end else begin
      irq_s_q     <= IRQ;
      irq_s2_q    <= irq_s_q;
      poll_pend_q <= poll_pend_d;
      poll_vld_q  <= poll_vld_d;
      poll_do_q   <= poll_do_d;
    end
  end

  assign PollVld = poll_vld_q;
  assign PollDO  = poll_do_q;
`endif

  assign AckA     = acka_q;
  assign AckB     = ackb_q;
  assign DOA      = doa_q;
  assign DOB      = dob_q;
  assign SSP_SSEL = ssel_q;
  assign SSP_SCK  = sck_q;
  assign SSP_RA   = ra_q;
  assign SSP_WnR  = wnr_q;
  assign SSP_En   = en_q;
  assign SSP_EOC  = eoc_q;
  assign SSP_DI   = di_q;
  assign Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ssp_uart_cmd_seq.sv
// Directed bench for ssp_uart_cmd_seq: one instance with SCK divider 1 and one
// with divider 3. Inputs are driven and outputs sampled on the falling edge.
module tb_ssp_uart_cmd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Divider-1 instance
  logic        rst1 = 1'b1;
  logic        req_a1 = 0, wnr_a1 = 0, req_b1 = 0, wnr_b1 = 0;
  logic [2:0]  ra_a1 = '0, ra_b1 = '0;
  logic [11:0] di_a1 = '0, di_b1 = '0, sdo1 = '0;
  logic        ack_a1, ack_b1, ssel1, sck1, wnr1, en1, eoc1, busy1;
  logic [11:0] do_a1, do_b1, di1;
  logic [2:0]  ra1;
  // Divider-3 instance
  logic        rst3 = 1'b1;
  logic        req_a3 = 0, wnr_a3 = 0;
  logic [2:0]  ra_a3 = '0;
  logic [11:0] di_a3 = '0;
  logic        ack_a3, ack_b3, ssel3, sck3, wnr3, en3, eoc3, busy3;
  logic [11:0] do_a3, do_b3, di3;
  logic [2:0]  ra3;
`ifdef SSP_SEQ_IRQ_POLL_EN
  logic        irq1 = 1'b0, irq3 = 1'b0, pvld1, pvld3;
  logic [11:0] pdo1, pdo3;
`endif

  ssp_uart_cmd_seq #(.pSCK_Div(1), .pPollRA(3'b000)) dut1 (
    .Clk(clk), .Rst(rst1),
    .ReqA(req_a1), .WnRA(wnr_a1), .RAA(ra_a1), .DIA(di_a1), .AckA(ack_a1), .DOA(do_a1),
    .ReqB(req_b1), .WnRB(wnr_b1), .RAB(ra_b1), .DIB(di_b1), .AckB(ack_b1), .DOB(do_b1),
    .SSP_SSEL(ssel1), .SSP_SCK(sck1), .SSP_RA(ra1), .SSP_WnR(wnr1), .SSP_En(en1),
    .SSP_EOC(eoc1), .SSP_DI(di1), .SSP_DO(sdo1),
`ifdef SSP_SEQ_IRQ_POLL_EN
    .IRQ(irq1), .PollVld(pvld1), .PollDO(pdo1),
`endif
    .Busy(busy1));

  ssp_uart_cmd_seq #(.pSCK_Div(3), .pPollRA(3'b000)) dut3 (
    .Clk(clk), .Rst(rst3),
    .ReqA(req_a3), .WnRA(wnr_a3), .RAA(ra_a3), .DIA(di_a3), .AckA(ack_a3), .DOA(do_a3),
    .ReqB(1'b0), .WnRB(1'b0), .RAB(3'b000), .DIB(12'h000), .AckB(ack_b3), .DOB(do_b3),
    .SSP_SSEL(ssel3), .SSP_SCK(sck3), .SSP_RA(ra3), .SSP_WnR(wnr3), .SSP_En(en3),
    .SSP_EOC(eoc3), .SSP_DI(di3), .SSP_DO(12'h000),
`ifdef SSP_SEQ_IRQ_POLL_EN
    .IRQ(irq3), .PollVld(pvld3), .PollDO(pdo3),
`endif
    .Busy(busy3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Per-frame measurements on dut1, cycle 0 = IDLE sample cycle.
  int m_ack, m_ssel_first, m_ssel_last, m_eoc_cyc, m_eoc_cnt, m_en_cnt, m_rise;
  int m_hold_err, m_other_ack;
  logic [11:0] m_do, m_do_other;

  task automatic run1(input logic is_b, input logic wnr, input logic [2:0] ra,
                      input logic [11:0] di, input logic [11:0] sdo);
    logic sck_prev;
    @(negedge clk);
    sdo1 = sdo;
    if (is_b) begin req_b1 = 1; wnr_b1 = wnr; ra_b1 = ra; di_b1 = di; end
    else      begin req_a1 = 1; wnr_a1 = wnr; ra_a1 = ra; di_a1 = di; end
    m_ack = -1; m_ssel_first = -1; m_ssel_last = -1; m_eoc_cyc = -1;
    m_eoc_cnt = 0; m_en_cnt = 0; m_rise = 0; m_hold_err = 0; m_other_ack = 0;
    m_do = '0; m_do_other = '0; sck_prev = 0;
    for (int c = 1; c <= 200 && m_ack < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (ssel1) begin
        if (m_ssel_first < 0) m_ssel_first = c;
        m_ssel_last = c;
        if (ra1 !== ra || wnr1 !== wnr || di1 !== di) m_hold_err++;
      end
      if (eoc1) begin m_eoc_cnt++; m_eoc_cyc = c; end
      if (en1) m_en_cnt++;
      if (sck1 && !sck_prev) m_rise++;
      sck_prev = sck1;
      if (is_b ? ack_a1 : ack_b1) m_other_ack++;
      if (is_b ? ack_b1 : ack_a1) begin
        m_ack = c;
        m_do = is_b ? do_b1 : do_a1;
        m_do_other = is_b ? do_a1 : do_b1;
        req_a1 = 0; req_b1 = 0;
      end
    end
    req_a1 = 0; req_b1 = 0;
  endtask

  initial begin
    int ack_cyc[4], ack_who[4], rise_cyc[4], rise_ra[4];
    int n_ack, n_rise, cnt, t_rise1, t_rise2, t_fall1, t_ack, t_rises;
    logic prev, prev3;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {ssel1, sck1, en1, eoc1, ack_a1, ack_b1, busy1}, 0);
    check_eq("rst_data", {ra1, wnr1, di1, do_a1, do_b1}, 0);
    rst1 = 0; rst3 = 0;

    // T1: write A, RA=3, DI=0x5A5; SSP_DO must not reach DOA
    run1(0, 1, 3'd3, 12'h5A5, 12'hFFF);
    check_eq("t1_ack_cyc", m_ack, 35);
    check_eq("t1_ssel_first", m_ssel_first, 1);
    check_eq("t1_ssel_last", m_ssel_last, 34);
    check_eq("t1_eoc_cyc", m_eoc_cyc, 34);
    check_eq("t1_eoc_cnt", m_eoc_cnt, 1);
    check_eq("t1_en_cycles", m_en_cnt, 24);
    check_eq("t1_sck_rises", m_rise, 16);
    check_eq("t1_hold", m_hold_err, 0);
    check_eq("t1_other_ack", m_other_ack, 0);
    check_eq("t1_doa_write", m_do, 12'h000);
    @(negedge clk);
    check_eq("t1_busy_idle", busy1, 0);

    // T2: read B RA=5 -> DOB=0xABC, DOA unchanged; then A read, B write
    run1(1, 0, 3'd5, 12'h000, 12'hABC);
    check_eq("t2_ack_cyc", m_ack, 35);
    check_eq("t2_dob", m_do, 12'hABC);
    check_eq("t2_doa_keep", m_do_other, 12'h000);
    check_eq("t2_hold", m_hold_err, 0);
    run1(0, 0, 3'd1, 12'h000, 12'h123);
    check_eq("t2_doa_read", m_do, 12'h123);
    check_eq("t2_dob_keep", m_do_other, 12'hABC);
    run1(1, 1, 3'd7, 12'h0F0, 12'h555);
    check_eq("t2_dob_write_keep", m_do, 12'hABC);

    // T3: both requests held from reset, four frames, A,B,A,B
    @(negedge clk);
    rst1 = 1;
    req_a1 = 1; wnr_a1 = 0; ra_a1 = 3'd1;
    req_b1 = 1; wnr_b1 = 0; ra_b1 = 3'd2;
    sdo1 = 12'h111;
    @(posedge clk); @(negedge clk);
    rst1 = 0;
    n_ack = 0; n_rise = 0; prev = 0;
    for (int c = 1; c <= 400 && n_ack < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (ssel1 && !prev && n_rise < 4) begin
        rise_cyc[n_rise] = c; rise_ra[n_rise] = int'(ra1); n_rise++;
      end
      prev = ssel1;
      if (ack_a1 || ack_b1) begin
        ack_cyc[n_ack] = c; ack_who[n_ack] = ack_b1 ? 1 : 0; n_ack++;
        if (n_ack == 4) begin req_a1 = 0; req_b1 = 0; end
      end
    end
    req_a1 = 0; req_b1 = 0;
    check_eq("t3_frames", n_ack, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_ack) begin
        check_eq($sformatf("t3_ack_cyc%0d", i), ack_cyc[i], 35 + 36 * i);
        check_eq($sformatf("t3_owner%0d", i), ack_who[i], i % 2);
      end
      if (i < n_rise) begin
        check_eq($sformatf("t3_ssel_rise%0d", i), rise_cyc[i], 1 + 36 * i);
        check_eq($sformatf("t3_ra%0d", i), rise_ra[i], (i % 2) + 1);
      end
    end

    // T4: reset at cycle 10 of an A frame, then a full re-issued frame
    @(negedge clk);
    req_a1 = 1; wnr_a1 = 1; ra_a1 = 3'd6; di_a1 = 12'h321;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    check_eq("t4_pre_ssel", ssel1, 1);
    rst1 = 1; req_a1 = 0;
    @(posedge clk); @(negedge clk);
    check_eq("t4_abort", {ssel1, sck1, en1, busy1}, 0);
    rst1 = 0;
    cnt = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (ack_a1) cnt++; end
    check_eq("t4_no_ack", cnt, 0);
    run1(0, 1, 3'd6, 12'h321, 12'h000);
    check_eq("t4_reissue_ack", m_ack, 35);
    check_eq("t4_reissue_rises", m_rise, 16);

    // T5: divider 3 -> SCK 3 low / 3 high, Ack at 101
    @(negedge clk);
    req_a3 = 1; wnr_a3 = 1; ra_a3 = 3'd2; di_a3 = 12'h0AA;
    t_rise1 = -1; t_rise2 = -1; t_fall1 = -1; t_ack = -1; t_rises = 0; prev3 = 0; cnt = 0;
    for (int c = 1; c <= 300 && t_ack < 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (sck3 && !prev3) begin
        t_rises++;
        if (t_rise1 < 0) t_rise1 = c; else if (t_rise2 < 0) t_rise2 = c;
      end
      if (!sck3 && prev3 && t_fall1 < 0) t_fall1 = c;
      prev3 = sck3;
      if (ack_b3) cnt++;
      if (ack_a3) begin t_ack = c; req_a3 = 0; end
    end
    req_a3 = 0;
    check_eq("t5_first_rise", t_rise1, 7);
    check_eq("t5_first_fall", t_fall1, 10);
    check_eq("t5_second_rise", t_rise2, 13);
    check_eq("t5_rises", t_rises, 16);
    check_eq("t5_ack_cyc", t_ack, 101);
    check_eq("t5_no_ackb", cnt, 0);

`ifdef SSP_SEQ_IRQ_POLL_EN
    // T6: IRQ during A frame with B pending -> A, poll of RA 0, then B
    begin
      int c_a, c_p, c_b, p_ra, p_wnr;
      logic [11:0] p_do;
      @(negedge clk);
      rst1 = 1;
      @(posedge clk); @(negedge clk);
      rst1 = 0;
      req_a1 = 1; wnr_a1 = 1; ra_a1 = 3'd1; di_a1 = 12'h00F;
      req_b1 = 1; wnr_b1 = 0; ra_b1 = 3'd4;
      sdo1 = 12'h3C3; irq1 = 0;
      c_a = -1; c_p = -1; c_b = -1; p_ra = -1; p_wnr = -1; p_do = '0; n_rise = 0; prev = 0;
      for (int c = 1; c <= 300 && c_b < 0; c++) begin
        @(posedge clk); @(negedge clk);
        if (c == 5) irq1 = 1;
        if (ssel1 && !prev) begin
          n_rise++;
          if (n_rise == 2) begin p_ra = int'(ra1); p_wnr = int'(wnr1); end
        end
        prev = ssel1;
        if (ack_a1) begin c_a = c; req_a1 = 0; end
        if (pvld1) begin c_p = c; p_do = pdo1; end
        if (ack_b1) begin c_b = c; req_b1 = 0; end
      end
      req_a1 = 0; req_b1 = 0; irq1 = 0;
      check_eq("t6_acka", c_a, 35);
      check_eq("t6_poll_vld", c_p, 71);
      check_eq("t6_poll_do", p_do, 12'h3C3);
      check_eq("t6_poll_ra", p_ra, 0);
      check_eq("t6_poll_wnr", p_wnr, 0);
      check_eq("t6_ackb", c_b, 107);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
